gl_vga_text_overlay: RTL

Character-cell text overlay stage sitting directly downstream of the GL_VGA timing/pattern generator. It consumes that block's pixel enable, blanking, sync and RGB outputs and superimposes an 80x60 grid of 8x8 glyphs, held in an internal character buffer, onto the incoming picture. The font is supplied by an external font ROM. All video outputs are delayed by a fixed three-pixel pipeline, so sync, blank and colour stay mutually aligned for the MiSTer video path.

---
 rtl/gl_vga_text_overlay.sv | 127 ++++++++++++
 1 files changed

// File: rtl/gl_vga_text_overlay.sv
// Superimposes an 80x60 grid of 8x8 glyphs from an internal character buffer onto the upstream picture.
// Latency: 3 ce_pix events, identical for colour, blank and sync, so all video outputs stay aligned.
// No backpressure: every stage advances only when ce_pix=1 and holds otherwise; buffer writes ignore ce_pix.
module gl_vga_text_overlay #(
  parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
  parameter int          COLS     = 80,
  parameter int          ROWS     = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        HBlank_in,
  input  logic        VBlank_in,
  input  logic        HSync_in,
  input  logic        VSync_in,
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  input  logic        overlay_en,
  input  logic        wr_en,
  input  logic [12:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        HBlank,
  output logic        VBlank,
  output logic        HSync,
  output logic        VSync,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b
);

  localparam int         CELLS = COLS * ROWS;
  localparam logic [9:0] XMAX  = 10'(COLS * 8 - 1);
  localparam logic [9:0] YMAX  = 10'(ROWS * 8 - 1);

  typedef struct packed {
    logic        hblank;
    logic        vblank;
    logic        hsync;
    logic        vsync;
    logic [23:0] rgb;
  } vid_t;

  logic [7:0]  mem [0:CELLS-1];
  logic [7:0]  char_code;
  logic [12:0] rd_addr;
  logic [9:0]  px;
  logic [9:0]  py;
  logic        hb_q;

  vid_t        vin;
  vid_t        s0_v;
  vid_t        s1_v;
  vid_t        out_v;
  logic        s0_act;
  logic        s1_act;
  logic        s1_nz;
  logic [2:0]  s0_px3;
  logic [2:0]  s1_px3;
  logic [2:0]  s0_py3;
  logic        sel;

  assign vin     = {HBlank_in, VBlank_in, HSync_in, VSync_in, r_in, g_in, b_in};
  assign rd_addr = 13'(int'(py[9:3]) * COLS + int'(px[9:3]));
  // Leftmost pixel of the glyph row is bit 7.
  assign sel     = font_data[3'd7 - s1_px3];
  assign {HBlank, VBlank, HSync, VSync, r, g, b} = out_v;

  // Character buffer: out-of-range writes dropped, read-before-write on address collision, never cleared.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < 13'(CELLS)))
      mem[wr_addr] <= wr_data;
    if (ce_pix)
      char_code <= mem[rd_addr];
  end

  // Beam position: px restarts every HBlank, py counts HBlank rising edges; both saturate at the grid edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      px   <= '0;
      py   <= '0;
      hb_q <= 1'b0;
    end else if (ce_pix) begin
      hb_q <= HBlank_in;
      if (HBlank_in)
        px <= '0;
      else if (px != XMAX)
        px <= px + 10'd1;
      if (VBlank_in)
        py <= '0;
      else if (HBlank_in && !hb_q && (py != YMAX))
        py <= py + 10'd1;
    end
  end

  // Three-stage video pipeline: S0 capture + buffer read, S1 font lookup, then colour select into the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_v      <= '0;
      s1_v      <= '0;
      out_v     <= '0;
      s0_act    <= 1'b0;
      s1_act    <= 1'b0;
      s1_nz     <= 1'b0;
      s0_px3    <= '0;
      s1_px3    <= '0;
      s0_py3    <= '0;
      font_addr <= '0;
    end else if (ce_pix) begin
      s0_v      <= vin;
      s0_act    <= overlay_en && !HBlank_in && !VBlank_in;
      s0_px3    <= px[2:0];
      s0_py3    <= py[2:0];
      s1_v      <= s0_v;
      s1_act    <= s0_act;
      s1_px3    <= s0_px3;
      s1_nz     <= (char_code != 8'h00);
      font_addr <= {char_code, s0_py3};
      out_v     <= s1_v;
      if (s1_act && s1_nz && sel)
        out_v.rgb <= FG_COLOR;
    end
  end

endmodule
